float_triple_collector: RTL and testbench

Upstream feeder for the three-float FSM sorter. It accepts a serial stream of FLEN-bit floating-point words with a valid/ready handshake and packs them into groups of three. Completed groups are queued in a two-entry group FIFO and presented to the sorter's `valid_in`/`unsorted` inputs, held off by the sorter's `busy`. Incomplete groups closed by `in_last` are padded or dropped, selected at compile time.

---
 rtl/float_triple_collector_pkg.sv | 29 ++
 rtl/float_triple_collector_group_fifo.sv | 47 ++++
 rtl/float_triple_collector.sv | 115 +++++++++++
 tb/tb_float_triple_collector.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/float_triple_collector_pkg.sv
// Shared types and constants for the float triple collector (see FLOAT_COLLECT_PAD_EN in the top).
package float_triple_collector_pkg;

  localparam int FLEN  = 64;
  localparam int EXP_W = (FLEN == 64) ? 11 : 8;

  localparam logic [31:0] FP32_POS_INF = 32'h7F80_0000;
  localparam logic [63:0] FP64_POS_INF = 64'h7FF0_0000_0000_0000;

  typedef enum logic [1:0] {
    FILL0 = 2'd0,
    FILL1 = 2'd1,
    FILL2 = 2'd2
  } fill_state_t;

  typedef struct packed {
    logic [0:2][FLEN-1:0] words;
    logic [2:0]           mask;
  } group_t;

  // +Infinity for whatever FLEN is active: sign 0, exponent all ones, mantissa 0.
  function automatic logic [FLEN-1:0] pos_inf();
    logic [FLEN-1:0] w;
    w = {FLEN{1'b0}};
    w[FLEN-2 -: EXP_W] = {EXP_W{1'b1}};
    return w;
  endfunction

endpackage

// File: rtl/float_triple_collector_group_fifo.sv
// Two-entry register FIFO of float groups; head is always a register so the sorter sees stable data.
module float_group_fifo
  import float_triple_collector_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  group_t     push_data,
  input  logic       pop,
  output group_t     head,
  output logic [1:0] count
);

  group_t tail;

  // Shift-register FIFO: pop moves tail into head, push lands in the first free slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= {$bits(group_t){1'b0}};
      tail  <= {$bits(group_t){1'b0}};
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) head <= push_data;
          else               tail <= push_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            head <= push_data;
          end else begin
            head <= tail;
            tail <= push_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/float_triple_collector.sv
// Packs a float word stream into groups of three for the sorter.
// FLOAT_COLLECT_PAD_EN: short groups are padded with +Inf instead of dropped.
module float_triple_collector
  import float_triple_collector_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [FLEN-1:0]      in_data,
  input  logic                 in_last,
  output logic                 valid_out,
  output logic [0:2][FLEN-1:0] unsorted,
  output logic [2:0]           pad_mask,
  input  logic                 busy,
  output logic [7:0]           short_cnt
);

  fill_state_t     state;
  logic [FLEN-1:0] asm0;
  logic [FLEN-1:0] asm1;
  logic            accept;
  logic            push;
  logic            pop;
  group_t          push_grp;
  group_t          head;
  logic [1:0]      fifo_count;

  assign in_ready  = (fifo_count != 2'd2);
  assign valid_out = (fifo_count != 2'd0);
  assign accept    = in_valid && in_ready;
  assign pop       = valid_out && !busy;
  assign unsorted  = head.words;
  // Without padding only full groups are pushed, so the mask register stays 0.
  assign pad_mask  = head.mask;

  // Group to push this cycle, if the accepted word closes one.
  always_comb begin
    push     = 1'b0;
    push_grp = {$bits(group_t){1'b0}};
    if (accept) begin
      case (state)
        FILL2: begin
          push           = 1'b1;
          push_grp.words = {asm0, asm1, in_data};
          push_grp.mask  = 3'b000;
        end
        FILL1: begin
          if (in_last) begin
`ifdef FLOAT_COLLECT_PAD_EN
            push           = 1'b1;
            push_grp.words = {asm0, in_data, pos_inf()};
            push_grp.mask  = 3'b100;
`else
            push           = 1'b0;
`endif
          end else begin
            push = 1'b0;
          end
        end
        default: begin
          if (in_last) begin
`ifdef FLOAT_COLLECT_PAD_EN
            push           = 1'b1;
            push_grp.words = {in_data, pos_inf(), pos_inf()};
            push_grp.mask  = 3'b110;
`else
            push           = 1'b0;
`endif
          end else begin
            push = 1'b0;
          end
        end
      endcase
    end else begin
      push = 1'b0;
    end
  end

  // Assembly FSM: state is the next slot to fill; in_last before slot 2 closes the group short.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FILL0;
      asm0      <= {FLEN{1'b0}};
      asm1      <= {FLEN{1'b0}};
      short_cnt <= 8'd0;
    end else if (accept) begin
      case (state)
        FILL0: begin
          asm0  <= in_data;
          state <= in_last ? FILL0 : FILL1;
        end
        FILL1: begin
          asm1  <= in_data;
          state <= in_last ? FILL0 : FILL2;
        end
        default: state <= FILL0;
      endcase
      if (in_last && (state != FILL2) && (short_cnt != 8'hFF)) begin
        short_cnt <= short_cnt + 8'd1;
      end
    end
  end

  float_group_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_grp),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_float_triple_collector.sv
// Self-checking bench for float_triple_collector, honours FLOAT_COLLECT_PAD_EN like the RTL.
module tb_float_triple_collector;
  import float_triple_collector_pkg::*;

  localparam logic [63:0] D1 = 64'h3FF0_0000_0000_0000;
  localparam logic [63:0] D2 = 64'h4000_0000_0000_0000;
  localparam logic [63:0] D3 = 64'h4008_0000_0000_0000;
  localparam logic [63:0] D4 = 64'h4010_0000_0000_0000;
  localparam logic [63:0] D5 = 64'h4014_0000_0000_0000;
  localparam logic [63:0] INF = 64'h7FF0_0000_0000_0000;

  logic                 clk = 1'b0;
  logic                 rst, in_valid, in_ready, in_last, valid_out, busy;
  logic [FLEN-1:0]      in_data;
  logic [0:2][FLEN-1:0] unsorted;
  logic [2:0]           pad_mask;
  logic [7:0]           short_cnt;

  int checks = 0;
  int errors = 0;
  int xfer   = 0;
  bit en     = 1'b0;

  typedef struct packed {
    logic [0:2][FLEN-1:0] w;
    logic [2:0]           m;
  } exp_t;

  exp_t            q[$];
  logic [FLEN-1:0] words[$];
  int              m_short = 0;

  float_triple_collector dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .valid_out(valid_out),
    .unsorted(unsorted), .pad_mask(pad_mask), .busy(busy), .short_cnt(short_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3*FLEN-1:0] act, input logic [3*FLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: a group list bounded at two, plus the words collected so far.
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      words.delete();
      m_short = 0;
      en = 1'b1;
    end else begin
      bit acc;
      acc = in_valid && (q.size() < 2);
      if (q.size() != 0 && !busy) void'(q.pop_front());
      if (acc) begin
        words.push_back(in_data);
        if (words.size() == 3 || in_last) begin
          exp_t g;
          bit full;
          full = (words.size() == 3);
          for (int i = 0; i < 3; i++) begin
            g.w[i] = (i < words.size()) ? words[i] : INF;
            g.m[i] = (i >= words.size());
          end
          if (!full && m_short < 255) m_short++;
`ifdef FLOAT_COLLECT_PAD_EN
          q.push_back(g);
`else
          if (full) q.push_back(g);
`endif
          words.delete();
        end
      end
    end
  end

  // Compare every cycle against the model, away from the rising edge.
  always @(negedge clk) begin
    if (en) begin
      chk("valid_out", {191'd0, valid_out}, {191'd0, q.size() != 0});
      chk("in_ready", {191'd0, in_ready}, {191'd0, q.size() < 2});
      chk("short_cnt", {184'd0, short_cnt}, {184'd0, 8'(m_short)});
      if (q.size() != 0) begin
        chk("unsorted", unsorted, q[0].w);
        chk("pad_mask", {189'd0, pad_mask}, {189'd0, q[0].m});
      end
      if (valid_out && !busy) xfer++;
    end
  end

  task automatic send(input logic [FLEN-1:0] d, input logic last);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=in_ready_low required=in_ready_high");
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; busy = 1'b0;
    idle(2);
    rst = 1'b0;
    chk("reset_valid", {191'd0, valid_out}, 192'd0);
    chk("reset_ready", {191'd0, in_ready}, 192'd1);
    chk("reset_short", {184'd0, short_cnt}, 192'd0);

    // 1.0, 3.0, 2.0 with the sorter idle
    send(D1, 1'b0); send(D3, 1'b0); send(D2, 1'b0);
    chk("t1_valid", {191'd0, valid_out}, 192'd1);
    chk("t1_unsorted", unsorted, {D1, D3, D2});
    chk("t1_mask", {189'd0, pad_mask}, 192'd0);
    idle(3);

    // six words against a busy sorter, then release
    busy = 1'b1;
    send(D1, 1'b0); send(D2, 1'b0); send(D3, 1'b0);
    send(D4, 1'b0); send(D5, 1'b0); send(D1, 1'b0);
    chk("t2_full_ready", {191'd0, in_ready}, 192'd0);
    chk("t2_full_head", unsorted, {D1, D2, D3});
    busy = 1'b0;
    @(negedge clk);
    chk("t2_ready_after_pop", {191'd0, in_ready}, 192'd1);
    chk("t2_second_head", unsorted, {D4, D5, D1});
    idle(3);

    // short group 5.0, 4.0
    send(D5, 1'b0); send(D4, 1'b1);
    chk("t3_short", {184'd0, short_cnt}, 192'd1);
`ifdef FLOAT_COLLECT_PAD_EN
    chk("t3_valid", {191'd0, valid_out}, 192'd1);
    chk("t3_unsorted", unsorted, {D5, D4, INF});
    chk("t3_mask", {189'd0, pad_mask}, {189'd0, 3'b100});
`else
    chk("t3_valid", {191'd0, valid_out}, 192'd0);
`endif
    idle(3);

    // in_last on the third word is a normal full group
    send(D2, 1'b0); send(D3, 1'b0); send(D1, 1'b1);
    chk("t4_valid", {191'd0, valid_out}, 192'd1);
    chk("t4_unsorted", unsorted, {D2, D3, D1});
    chk("t4_short", {184'd0, short_cnt}, 192'd1);
    idle(3);

    // reset with a queued group and a partial one
    busy = 1'b1;
    send(D1, 1'b0); send(D2, 1'b0); send(D3, 1'b0);
    send(D4, 1'b0); send(D5, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_valid", {191'd0, valid_out}, 192'd0);
    chk("t5_short", {184'd0, short_cnt}, 192'd0);
    rst = 1'b0;
    busy = 1'b0;
    xfer = 0;
    send(D3, 1'b0); send(D2, 1'b0); send(D1, 1'b0);
    chk("t5_head", unsorted, {D3, D2, D1});
    idle(5);
    chk("t5_groups", 192'(xfer), 192'd1);

    // saturation of the short-group counter
    for (int i = 0; i < 260; i++) send(64'(i), 1'b1);
    idle(4);
    chk("t6_saturate", {184'd0, short_cnt}, 192'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
